lcd_cfg_sequencer: RTL and testbench
====================================

Name: lcd_cfg_sequencer

Overview:
- Parametrised serial-panel configuration sequencer.
- Walks an external register LUT and issues one frame per entry to the serial (I2S-style 3-wire) controller over a STR/RDY/ACK handshake.
- Adds bounded NACK retry, an inter-frame gap, re-triggerable runs and DONE/ERR status, generalised in address/data width and table depth.
- Sits between the panel ROM (lcd_cfg_lut) and the serial controller, clocked by the controller's serial clock.

Parameters:
- ADDR_W, 6: register address field width.
- DATA_W, 8: register data field width.
- FRAME_W, ADDR_W+2+DATA_W: frame width, laid out as {addr, 2'b00, data}; derived, not overridden.
- LUT_SIZE, 9: number of LUT entries; legal range 1..2**IDX_W.
- IDX_W, 6: index width.
- MAX_RETRY, 3: re-sends allowed per entry after a NACK; 0 means no retry.
- GAP_CYC, 4: idle mI2S_CLK cycles between frames; 0 means no gap.
- AUTO_START, 1: start a run automatically on reset release.

Ports:
- mI2S_CLK  in  1  sequencer clock (serial controller clock)
- iRST_N  in  1  reset, asynchronous, active-low
- iSTART  in  1  one-cycle pulse; starts a run when idle
- oLUT_INDEX  out  IDX_W  current entry index to the LUT
- iLUT_DATA  in  FRAME_W  frame for oLUT_INDEX; combinational, valid the same cycle
- oDATA  out  FRAME_W  frame to the serial controller
- oSTR  out  1  start strobe to the serial controller
- iRDY  in  1  serial controller finished the frame
- iACK  in  1  slave acknowledged; sampled together with iRDY
- oBUSY  out  1  run in progress
- oDONE  out  1  last run completed; sticky until the next run starts
- oERR  out  1  at least one entry exhausted its retries in the last run
- oERR_IDX  out  IDX_W  index of the first failing entry

Behaviour:
- Reset values: oSTR=0, oDATA=0, oLUT_INDEX=0, oBUSY=0, oDONE=0, oERR=0, oERR_IDX=0; retry counter and gap counter = 0; state IDLE.
- Reset is asynchronous. Assertion mid-frame aborts immediately with oSTR=0. After release with AUTO_START=1, the run begins at index 0.
- start_pending is set by reset release (if AUTO_START) or by iSTART while in IDLE or DONE. iSTART during oBUSY=1 is ignored.
- IDLE / DONE:
  - On start_pending → LOAD.
  - On that transition: index=0, retry=0, oDONE=0, oERR=0, oERR_IDX=0, oBUSY=1.
- LOAD (1 cycle): oDATA<=iLUT_DATA, oSTR<=1 → BLANK.
- BLANK (1 cycle): iRDY ignored, since the controller needs a cycle to drop RDY → WAIT.
- WAIT: hold oSTR=1 until iRDY=1. Then oSTR<=0 and:
  - iACK=1 → NEXT.
  - iACK=0 and retry<MAX_RETRY → retry++, → GAP, then LOAD the same index.
  - iACK=0 and retry==MAX_RETRY → if oERR==0, set oERR=1 and oERR_IDX=index; → NEXT. The failing entry is skipped and the run continues.
- NEXT: retry=0.
  - If index==LUT_SIZE-1 → DONE with oBUSY<=0, oDONE<=1; index is held.
  - Otherwise index++ and → GAP.
- GAP: count GAP_CYC cycles, then → LOAD. With GAP_CYC=0, pass straight through in 0 extra cycles.
- Latency per clean frame: LOAD+BLANK+WAIT(n)+NEXT+GAP_CYC cycles, where n is controller-dependent.
- Index never wraps; it stops at LUT_SIZE-1.
- oDATA is stable from LOAD until the next LOAD.

Optional Feature:
- Macro: LCD_CFG_RETRY_STAT_EN.
- Defined:
  - Adds port oRETRY_CNT (out, 8 bits): total NACK re-sends in the current run.
  - Cleared at run start; saturates at 8'hFF.
  - Reset value 0.
- Undefined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Shared package lcd_cfg_pkg holds:
  - state encodings (IDLE, LOAD, BLANK, WAIT, NEXT, GAP, DONE);
  - the frame-field constants (ADDR_W, DATA_W, pad width 2);
  - a function packing {addr, pad, data} into a frame.
- Sub-module: lcd_cfg_lut, the combinational panel table driven by oLUT_INDEX. It is instantiated beside the sequencer, not inside it, so one sequencer serves several panels.

Test Plan:
- Reset release, LUT_SIZE=9, controller always ACKs → 9 frames sent in index order 0..8, each oDATA matching the LUT; oDONE=1, oERR=0, oBUSY=0.
- Entry 3 NACKs twice then ACKs, MAX_RETRY=3 → entry 3 sent 3 times; oERR=0; oRETRY_CNT=2 with the macro defined.
- Entry 5 always NACKs, MAX_RETRY=3 → 4 sends of entry 5; oERR=1, oERR_IDX=5; entries 6..8 still sent; oDONE=1.
- GAP_CYC=4 → exactly 4 cycles with oSTR=0 between the NEXT of frame k and the LOAD of frame k+1; GAP_CYC=0 → the gap disappears.
- iSTART pulsed during a run → ignored. iSTART after DONE → oDONE cleared, run restarts at index 0, oERR cleared.
- iRST_N asserted during WAIT of entry 4 → oSTR=0 immediately, all outputs at reset values; after release the run restarts at index 0.

Source files
------------

// File: rtl/lcd_cfg_pkg.sv
// Shared frame layout, state encodings and frame packing for the LCD
// configuration sequencer and its panel tables.
package lcd_cfg_pkg;

    localparam int unsigned LCD_ADDR_W  = 6;
    localparam int unsigned LCD_DATA_W  = 8;
    localparam int unsigned LCD_PAD_W   = 2;
    localparam int unsigned LCD_FRAME_W = LCD_ADDR_W + LCD_PAD_W + LCD_DATA_W;
    localparam int unsigned LCD_IDX_W   = 6;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_BLANK = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_NEXT  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    typedef struct packed {
        logic [LCD_ADDR_W-1:0] addr;
        logic [LCD_PAD_W-1:0]  pad;
        logic [LCD_DATA_W-1:0] data;
    } lcd_frame_t;

    function automatic logic [LCD_FRAME_W-1:0] pack_frame(
        input logic [LCD_ADDR_W-1:0] addr,
        input logic [LCD_DATA_W-1:0] data
    );
        lcd_frame_t f;
        f.addr = addr;
        f.pad  = '0;
        f.data = data;
        return f;
    endfunction

endpackage

// File: rtl/lcd_cfg_lut.sv
// Combinational panel register table; sits beside the sequencer and is
// addressed by its oLUT_INDEX output. Unused indices return an all-zero frame.
module lcd_cfg_lut
    import lcd_cfg_pkg::*;
(
    input  logic [LCD_IDX_W-1:0]   index_i,
    output logic [LCD_FRAME_W-1:0] frame_o
);

    always_comb begin
        frame_o = '0;
        case (index_i)
            6'd0:    frame_o = pack_frame(6'h00, 8'h3F);
            6'd1:    frame_o = pack_frame(6'h01, 8'h80);
            6'd2:    frame_o = pack_frame(6'h02, 8'h00);
            6'd3:    frame_o = pack_frame(6'h03, 8'h02);
            6'd4:    frame_o = pack_frame(6'h04, 8'h0C);
            6'd5:    frame_o = pack_frame(6'h05, 8'h42);
            6'd6:    frame_o = pack_frame(6'h06, 8'h20);
            6'd7:    frame_o = pack_frame(6'h0A, 8'h60);
            6'd8:    frame_o = pack_frame(6'h0B, 8'h5A);
            default: frame_o = '0;
        endcase
    end

endmodule

// File: rtl/lcd_cfg_sequencer.sv
// Walks an external register LUT and sends one frame per entry to the serial
// controller, with NACK retry, inter-frame gap and DONE/ERR status.
// Optional macro LCD_CFG_RETRY_STAT_EN adds the oRETRY_CNT re-send counter.
module lcd_cfg_sequencer
    import lcd_cfg_pkg::*;
#(
    parameter int unsigned ADDR_W     = LCD_ADDR_W,
    parameter int unsigned DATA_W     = LCD_DATA_W,
    parameter int unsigned LUT_SIZE   = 9,
    parameter int unsigned IDX_W      = 6,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned GAP_CYC    = 4,
    parameter bit          AUTO_START = 1'b1,
    localparam int unsigned FRAME_W   = ADDR_W + 2 + DATA_W
) (
    input  logic               mI2S_CLK,
    input  logic               iRST_N,
    input  logic               iSTART,
    output logic [IDX_W-1:0]   oLUT_INDEX,
    input  logic [FRAME_W-1:0] iLUT_DATA,
    output logic [FRAME_W-1:0] oDATA,
    output logic               oSTR,
    input  logic               iRDY,
    input  logic               iACK,
    output logic               oBUSY,
    output logic               oDONE,
    output logic               oERR,
    output logic [IDX_W-1:0]   oERR_IDX
`ifdef LCD_CFG_RETRY_STAT_EN
    ,
    output logic [7:0]         oRETRY_CNT
`endif
);

    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(LUT_SIZE - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
    // With no gap, the frame after NEXT or a retry goes straight to LOAD.
    localparam logic [2:0]         ST_AFTER  = (GAP_CYC == 0) ? ST_LOAD : ST_GAP;

    logic [2:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [FRAME_W-1:0] data_q, data_d;
    logic               str_q, str_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   err_idx_q, err_idx_d;
    logic               pending_q, pending_d;
    logic               run_start;
    logic               resend;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        gap_d     = gap_q;
        data_d    = data_q;
        str_d     = str_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        pending_d = pending_q;
        run_start = 1'b0;
        resend    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (pending_q || iSTART) begin
                    run_start = 1'b1;
                    pending_d = 1'b0;
                    idx_d     = '0;
                    retry_d   = '0;
                    gap_d     = '0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    err_idx_d = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                data_d  = iLUT_DATA;
                str_d   = 1'b1;
                state_d = ST_BLANK;
            end
            ST_BLANK: state_d = ST_WAIT;
            ST_WAIT: begin
                if (iRDY) begin
                    str_d = 1'b0;
                    if (iACK) begin
                        state_d = ST_NEXT;
                    end else if (retry_q < RETRY_MAX) begin
                        resend  = 1'b1;
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_AFTER;
                    end else begin
                        // Only the first exhausted entry is reported; the run carries on.
                        if (!err_q) begin
                            err_d     = 1'b1;
                            err_idx_d = idx_q;
                        end
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                retry_d = '0;
                if (idx_q == LAST_IDX) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_AFTER;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = ST_LOAD;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge mI2S_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            retry_q   <= '0;
            gap_q     <= '0;
            data_q    <= '0;
            str_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            pending_q <= AUTO_START;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            gap_q     <= gap_d;
            data_q    <= data_d;
            str_q     <= str_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            pending_q <= pending_d;
        end
    end

`ifdef LCD_CFG_RETRY_STAT_EN
    logic [7:0] retry_cnt_q, retry_cnt_d;

    always_comb begin
        retry_cnt_d = retry_cnt_q;
        if (run_start) begin
            retry_cnt_d = '0;
        end else if (resend && retry_cnt_q != 8'hFF) begin
            retry_cnt_d = retry_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge mI2S_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            retry_cnt_q <= '0;
        end else begin
            retry_cnt_q <= retry_cnt_d;
        end
    end

    assign oRETRY_CNT = retry_cnt_q;
`endif

    assign oLUT_INDEX = idx_q;
    assign oDATA      = data_q;
    assign oSTR       = str_q;
    assign oBUSY      = busy_q;
    assign oDONE      = done_q;
    assign oERR       = err_q;
    assign oERR_IDX   = err_idx_q;

endmodule

// File: tb/tb_lcd_cfg_sequencer.sv
// Directed bench for lcd_cfg_sequencer: a responder models the serial controller,
// and a scoreboard queue holds the frames each run is expected to send.
`timescale 1ns/1ps
module tb_lcd_cfg_sequencer;
    import lcd_cfg_pkg::*;

    localparam int unsigned GAP_CYC   = 4;
    localparam int unsigned MAX_RETRY = 3;
    localparam int CTL_LAT  = 3;
    localparam int CTL_LAT0 = 2;

    typedef struct packed {
        logic [5:0]  idx;
        logic [15:0] frame;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst0_n, start;
    logic [5:0]  lut_idx, err_idx, lut_idx0, err_idx0;
    logic [15:0] lut_data, data, lut_data0, data0;
    logic        str, rdy, ack, busy, done, err;
    logic        str0, rdy0, ack0, busy0, done0, err0;
`ifdef LCD_CFG_RETRY_STAT_EN
    logic [7:0]  retry_cnt, retry_cnt0;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_tbl [9] = '{16'h003F, 16'h0480, 16'h0800, 16'h0C02, 16'h100C,
                                 16'h1442, 16'h1820, 16'h2860, 16'h2C5A};

    exp_t q[$];
    exp_t q0[$];
    exp_t mon_e, mon0_e;

    int   sends [9];
    int   nack_idx, nack_times;
    int   ctl_cnt, exp_low, low_run;
    bit   seen_frame;
    logic str_prev;
    int   ctl_cnt0, low_run0;
    bit   seen_frame0;
    logic str_prev0;

    lcd_cfg_lut u_lut (.index_i(lut_idx), .frame_o(lut_data));
    lcd_cfg_lut u_lut0 (.index_i(lut_idx0), .frame_o(lut_data0));

    lcd_cfg_sequencer #(
        .LUT_SIZE(9), .IDX_W(6), .MAX_RETRY(MAX_RETRY), .GAP_CYC(GAP_CYC), .AUTO_START(1'b1)
    ) dut (
        .mI2S_CLK(clk), .iRST_N(rst_n), .iSTART(start), .oLUT_INDEX(lut_idx),
        .iLUT_DATA(lut_data), .oDATA(data), .oSTR(str), .iRDY(rdy), .iACK(ack),
        .oBUSY(busy), .oDONE(done), .oERR(err), .oERR_IDX(err_idx)
`ifdef LCD_CFG_RETRY_STAT_EN
        , .oRETRY_CNT(retry_cnt)
`endif
    );

    // No gap and no retries: every NACK is immediately fatal for that entry.
    lcd_cfg_sequencer #(
        .LUT_SIZE(9), .IDX_W(6), .MAX_RETRY(0), .GAP_CYC(0), .AUTO_START(1'b1)
    ) dut0 (
        .mI2S_CLK(clk), .iRST_N(rst0_n), .iSTART(1'b0), .oLUT_INDEX(lut_idx0),
        .iLUT_DATA(lut_data0), .oDATA(data0), .oSTR(str0), .iRDY(rdy0), .iACK(ack0),
        .oBUSY(busy0), .oDONE(done0), .oERR(err0), .oERR_IDX(err_idx0)
`ifdef LCD_CFG_RETRY_STAT_EN
        , .oRETRY_CNT(retry_cnt0)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_range(input int first, input int last);
        for (int i = first; i <= last; i++) q.push_back({6'(i), exp_tbl[i]});
    endtask

    task automatic push_rep(input int idx, input int n);
        for (int i = 0; i < n; i++) q.push_back({6'(idx), exp_tbl[idx]});
    endtask

    task automatic clear_sends();
        for (int i = 0; i < 9; i++) sends[i] = 0;
        seen_frame = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Main controller model and scoreboard monitor.
    always @(negedge clk) begin
        if (str && !str_prev) begin
            if (q.size() == 0) begin
                chk("unexpected_frame", {26'd0, lut_idx}, 32'hFFFF);
            end else begin
                mon_e = q.pop_front();
                chk("frame_idx", lut_idx, mon_e.idx);
                chk("frame_data", data, mon_e.frame);
            end
            if (seen_frame) chk("gap_len", low_run, exp_low);
            seen_frame = 1'b1;
            low_run    = 0;
            if (lut_idx < 9) sends[lut_idx]++;
        end else if (!str && busy) begin
            low_run++;
        end
        if (!str) begin
            rdy     = 1'b0;
            ctl_cnt = 0;
        end else if (!rdy) begin
            ctl_cnt++;
            if (ctl_cnt >= CTL_LAT) begin
                rdy = 1'b1;
                ack = !(int'(lut_idx) == nack_idx && sends[lut_idx] <= nack_times);
                exp_low = (ack || sends[lut_idx] > MAX_RETRY) ? GAP_CYC + 2 : GAP_CYC + 1;
            end
        end
        str_prev = str;
    end

    // Controller for the no-gap instance; entry 2 is always refused.
    always @(negedge clk) begin
        if (str0 && !str_prev0) begin
            if (q0.size() == 0) begin
                chk("unexpected_frame0", {26'd0, lut_idx0}, 32'hFFFF);
            end else begin
                mon0_e = q0.pop_front();
                chk("frame0_idx", lut_idx0, mon0_e.idx);
                chk("frame0_data", data0, mon0_e.frame);
            end
            if (seen_frame0) chk("gap0_len", low_run0, 2);
            seen_frame0 = 1'b1;
            low_run0    = 0;
        end else if (!str0 && busy0) begin
            low_run0++;
        end
        if (!str0) begin
            rdy0     = 1'b0;
            ctl_cnt0 = 0;
        end else if (!rdy0) begin
            ctl_cnt0++;
            if (ctl_cnt0 >= CTL_LAT0) begin
                rdy0 = 1'b1;
                ack0 = (lut_idx0 != 6'd2);
            end
        end
        str_prev0 = str0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; rst0_n = 1'b0; start = 1'b0;
        rdy = 1'b0; ack = 1'b0; rdy0 = 1'b0; ack0 = 1'b0;
        str_prev = 1'b0; str_prev0 = 1'b0; ctl_cnt = 0; ctl_cnt0 = 0;
        low_run = 0; low_run0 = 0; exp_low = 0; seen_frame0 = 1'b0;
        nack_idx = 99; nack_times = 0;
        clear_sends();
        repeat (3) @(negedge clk);

        chk("rst_str", str, 0);
        chk("rst_data", data, 0);
        chk("rst_idx", lut_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_idx", err_idx, 0);

        // Run 1: auto-start on reset release, clean ACKs.
        push_range(0, 8);
        for (int i = 0; i < 9; i++) q0.push_back({6'(i), exp_tbl[i]});
        rst_n = 1'b1; rst0_n = 1'b1;
        @(negedge clk);
        chk("auto_busy", busy, 1);
        wait_done("run1_done", 400);
        chk("run1_sb_empty", q.size(), 0);
        chk("run1_err", err, 0);
        chk("run1_busy", busy, 0);
        chk("run1_idx_held", lut_idx, 8);
        n = 0;
        while (!done0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("nogap_done", done0, 1);
        chk("nogap_sb_empty", q0.size(), 0);
        chk("nogap_err", err0, 1);
        chk("nogap_err_idx", err_idx0, 2);
`ifdef LCD_CFG_RETRY_STAT_EN
        chk("nogap_retry_cnt", retry_cnt0, 0);
`endif

        // Run 2: entry 3 NACKs twice then ACKs; iSTART mid-run is ignored.
        clear_sends();
        nack_idx = 3; nack_times = 2;
        push_range(0, 3); push_rep(3, 2); push_range(4, 8);
        pulse_start();
        chk("run2_done_cleared", done, 0);
        chk("run2_busy", busy, 1);
        n = 0;
        while (lut_idx != 6'd5 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("run2_reach_idx5", lut_idx, 5);
        pulse_start();
        chk("run2_start_ignored", lut_idx, 5);
        wait_done("run2_done", 400);
        chk("run2_sb_empty", q.size(), 0);
        chk("run2_err", err, 0);
        chk("run2_sends3", sends[3], 3);
`ifdef LCD_CFG_RETRY_STAT_EN
        chk("run2_retry_cnt", retry_cnt, 2);
`endif

        // Run 3: entry 5 always NACKs; retries exhaust and the run continues.
        clear_sends();
        nack_idx = 5; nack_times = 1000;
        push_range(0, 5); push_rep(5, 3); push_range(6, 8);
        pulse_start();
        wait_done("run3_done", 500);
        chk("run3_sb_empty", q.size(), 0);
        chk("run3_err", err, 1);
        chk("run3_err_idx", err_idx, 5);
        chk("run3_busy", busy, 0);
`ifdef LCD_CFG_RETRY_STAT_EN
        chk("run3_retry_cnt", retry_cnt, 3);
`endif

        // Run 4: restart clears error, then reset lands in WAIT of entry 4.
        clear_sends();
        nack_idx = 99; nack_times = 0;
        push_range(0, 4);
        pulse_start();
        chk("run4_err_cleared", err, 0);
        chk("run4_err_idx_cleared", err_idx, 0);
        chk("run4_start_idx", lut_idx, 0);
        n = 0;
        while (!(lut_idx == 6'd4 && str) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("run4_reach_idx4", lut_idx, 4);
        @(negedge clk);
        chk("run4_in_wait", str, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_str", str, 0);
        chk("abort_data", data, 0);
        chk("abort_idx", lut_idx, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        chk("abort_sb_empty", q.size(), 0);
        clear_sends();
        push_range(0, 8);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_done("run5_done", 400);
        chk("run5_sb_empty", q.size(), 0);
        chk("run5_err", err, 0);
        chk("run5_idx_held", lut_idx, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
